// File: rtl/penc_seq_if.sv
// Purpose: bundles both handshake sides of the sequential priority-encoder
//   serializer (request vector in, index stream out) into one interface.
// Signals:
//   X[OPT-1:0]  request vector            (producer -> block)
//   X_VALID     X valid                   (producer -> block)
//   X_READY     block accepts X           (block -> producer)
//   Y[LEN-1:0]  current set-bit index     (block -> consumer)
//   Y_VALID     Y valid                   (block -> consumer)
//   Y_READY     consumer takes Y          (consumer -> block)
//   Y_LAST      Y is final index of vector(block -> consumer)
// Handshake: a transfer happens on a rising clock edge where VALID and READY
//   are both high; the sender holds its payload steady while VALID is high and
//   READY is low.
// Modports: slave = the serializer itself, master = the surrounding logic
//   (request producer plus index consumer).
interface penc_seq_if #(
  parameter int LEN = 4
);
  localparam int OPT = 2 ** LEN;

  logic [OPT-1:0] X;
  logic           X_VALID;
  logic           X_READY;
  logic [LEN-1:0] Y;
  logic           Y_VALID;
  logic           Y_READY;
  logic           Y_LAST;

  modport master (
    output X, X_VALID, Y_READY,
    input  X_READY, Y, Y_VALID, Y_LAST
  );

  modport slave (
    input  X, X_VALID, Y_READY,
    output X_READY, Y, Y_VALID, Y_LAST
  );
endinterface

// File: rtl/penc_seq.sv
// Purpose: sequential priority-encoder serializer. Accepts a request vector
//   and emits the index of every set bit, one per beat, lowest first
//   (MSB_FIRST=0) or highest first (MSB_FIRST=1). A vector with k set bits
//   occupies exactly k beats; a new vector can be taken on the last beat of
//   the current one, so back-to-back vectors stream without a bubble.
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   bus        penc_seq_if.slave: X/X_VALID/X_READY in, Y/Y_VALID/Y_READY/Y_LAST out
//   state_dbg  current FSM state (0 = IDLE, 1 = EMIT)
module penc_seq #(
  parameter int LEN       = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  penc_seq_if.slave  bus,
  output logic       state_dbg
);
  localparam int OPT = 2 ** LEN;
  localparam logic [OPT-1:0] ONE = OPT'(1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t         state, state_next;
  logic [OPT-1:0] pend, pend_next;
  logic [OPT-1:0] clr_mask;
  logic [LEN-1:0] idx;
  logic           single;
  logic           beat;
  logic           x_take;

  // Winning index of the pending set. The last assignment in scan order wins,
  // so scanning downward leaves the lowest set bit and upward the highest.
  always_comb begin : pick
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < OPT; i++) begin
        if (pend[i]) idx = LEN'(i);
      end
    end else begin
      for (int i = OPT - 1; i >= 0; i--) begin
        if (pend[i]) idx = LEN'(i);
      end
    end
  end

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign single   = (pend != '0) && ((pend & (pend - ONE)) == '0);
  assign clr_mask = ONE << idx;

  always_comb begin : outputs
    bus.Y_VALID = (state == EMIT);
    bus.Y       = (state == EMIT) ? idx : '0;
    bus.Y_LAST  = (state == EMIT) && single;
    if (rst) begin
      bus.X_READY = 1'b0;
    end else if (state == IDLE) begin
      bus.X_READY = 1'b1;
    end else begin
      // Refill only as the final index leaves, so a new vector never
      // overlaps bits still waiting to be emitted.
      bus.X_READY = single && bus.Y_READY;
    end
  end

  assign beat   = bus.Y_VALID && bus.Y_READY;
  assign x_take = bus.X_VALID && bus.X_READY;

  always_comb begin : next_state
    pend_next  = pend;
    state_next = state;
    if (beat) pend_next = pend & ~clr_mask;
    // x_take in EMIT implies the last bit just left, so loading X replaces
    // an empty set; an all-zero X therefore drops straight back to IDLE.
    if (x_take) pend_next = bus.X;
    state_next = (pend_next != '0) ? EMIT : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_next;
      pend  <= pend_next;
    end
  end

  assign state_dbg = (state == EMIT);
endmodule

// File: tb/tb_penc_seq.sv
module tb_penc_seq;
  localparam int LEN = 4;
  localparam int OPT = 2 ** LEN;
  localparam int OW  = LEN + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [OPT-1:0] x       = '0;
  logic           x_valid = 1'b0;
  logic           y_ready = 1'b1;
  logic           st_min, st_max;

  penc_seq_if #(.LEN(LEN)) bus_min ();
  penc_seq_if #(.LEN(LEN)) bus_max ();

  // Both orderings see identical stimulus; beat timing is order independent.
  assign bus_min.X       = x;
  assign bus_min.X_VALID = x_valid;
  assign bus_min.Y_READY = y_ready;
  assign bus_max.X       = x;
  assign bus_max.X_VALID = x_valid;
  assign bus_max.Y_READY = y_ready;

  penc_seq #(.LEN(LEN), .MSB_FIRST(1'b0)) dut_min (
    .clk(clk), .rst(rst), .bus(bus_min), .state_dbg(st_min)
  );
  penc_seq #(.LEN(LEN), .MSB_FIRST(1'b1)) dut_max (
    .clk(clk), .rst(rst), .bus(bus_max), .state_dbg(st_max)
  );

  // Observed bundle: {state, Y_VALID, Y, Y_LAST, X_READY}
  logic [OW-1:0] obs_min, obs_max;
  assign obs_min = {st_min, bus_min.Y_VALID, bus_min.Y, bus_min.Y_LAST, bus_min.X_READY};
  assign obs_max = {st_max, bus_max.Y_VALID, bus_max.Y, bus_max.Y_LAST, bus_max.X_READY};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Indices still owed for the current vector, in emission order.
  logic [LEN-1:0] exp_min_q[$];
  logic [LEN-1:0] exp_max_q[$];

  task automatic load_model(input logic [OPT-1:0] v);
    for (int i = 0; i < OPT; i++) begin
      if (v[i]) begin
        exp_min_q.push_back(LEN'(i));
        exp_max_q.push_front(LEN'(i));
      end
    end
  endtask

  function automatic logic [OW-1:0] model_out(input bit msb_first, input logic rdy);
    logic v, last;
    logic [LEN-1:0] y;
    v    = (exp_min_q.size() != 0);
    last = (exp_min_q.size() == 1);
    y    = '0;
    if (v) y = msb_first ? exp_max_q[0] : exp_min_q[0];
    return {v, v, y, last, (!v) | (last & rdy)};
  endfunction

  // Advance one clock: apply this cycle's handshakes to the model, then move
  // to just after the next rising edge where the next stimulus is applied.
  task automatic tick();
    logic v, last, xr;
    v    = (exp_min_q.size() != 0);
    last = (exp_min_q.size() == 1);
    xr   = !v || (last && y_ready);
    if (v && y_ready) begin
      void'(exp_min_q.pop_front());
      void'(exp_max_q.pop_front());
    end
    if (x_valid && xr && !rst) load_model(x);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; x = 16'h00FF; x_valid = 1'b1; y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (obs_min !== '0) begin
      errors++; $display("FAIL reset_min: got %b want %b", obs_min, {OW{1'b0}});
    end
    checks++;
    if (obs_max !== '0) begin
      errors++; $display("FAIL reset_max: got %b want %b", obs_max, {OW{1'b0}});
    end
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_min_q.delete(); exp_max_q.delete();
    @(negedge clk);
    checks++;
    if (obs_min !== 8'b0_0_0000_0_1) begin
      errors++; $display("FAIL reset_release_idle: got %b want %b", obs_min, 8'b0_0_0000_0_1);
    end
    tick();
  endtask

  // X=0x0005: min order 0 then 2(LAST); max order 2 then 0(LAST).
  task automatic test_min_order();
    logic [OW-1:0] want_min[4];
    logic [OW-1:0] want_max[4];
    want_min = '{8'b0_0_0000_0_1, 8'b1_1_0000_0_0, 8'b1_1_0010_1_1, 8'b0_0_0000_0_1};
    want_max = '{8'b0_0_0000_0_1, 8'b1_1_0010_0_0, 8'b1_1_0000_1_1, 8'b0_0_0000_0_1};
    y_ready = 1'b1; x = 16'h0005; x_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs_min !== want_min[c]) begin
        errors++; $display("FAIL min_order_x0005 cyc%0d: got %b want %b", c, obs_min, want_min[c]);
      end
      checks++;
      if (obs_max !== want_max[c]) begin
        errors++; $display("FAIL max_order_x0005 cyc%0d: got %b want %b", c, obs_max, want_max[c]);
      end
      tick();
      x_valid = 1'b0;
    end
  endtask

  // X=0x8001: max order 15 then 0(LAST); min order 0 then 15(LAST).
  task automatic test_max_order();
    logic [OW-1:0] want_min[3];
    logic [OW-1:0] want_max[3];
    want_min = '{8'b1_1_0000_0_0, 8'b1_1_1111_1_1, 8'b0_0_0000_0_1};
    want_max = '{8'b1_1_1111_0_0, 8'b1_1_0000_1_1, 8'b0_0_0000_0_1};
    y_ready = 1'b1; x = 16'h8001; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs_max !== want_max[c]) begin
        errors++; $display("FAIL max_order_x8001 cyc%0d: got %b want %b", c, obs_max, want_max[c]);
      end
      checks++;
      if (obs_min !== want_min[c]) begin
        errors++; $display("FAIL min_order_x8001 cyc%0d: got %b want %b", c, obs_min, want_min[c]);
      end
      tick();
    end
  endtask

  // X=0x0012 with the consumer stalled 3 cycles: first index held steady.
  task automatic test_backpressure();
    logic rdy_pat[7];
    int held_min, held_max;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    held_min = 0; held_max = 0;
    x = 16'h0012; x_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      y_ready = rdy_pat[c];
      @(negedge clk);
      if (bus_min.Y_VALID && bus_min.Y == 4'd1) held_min++;
      if (bus_max.Y_VALID && bus_max.Y == 4'd4) held_max++;
      checks++;
      if (obs_min !== model_out(1'b0, y_ready)) begin
        errors++; $display("FAIL backpressure_min cyc%0d: got %b want %b", c, obs_min, model_out(1'b0, y_ready));
      end
      checks++;
      if (obs_max !== model_out(1'b1, y_ready)) begin
        errors++; $display("FAIL backpressure_max cyc%0d: got %b want %b", c, obs_max, model_out(1'b1, y_ready));
      end
      tick();
      x_valid = 1'b0;
    end
    checks++;
    if (held_min !== 4) begin
      errors++; $display("FAIL backpressure_hold_min: got %0d cycles want 4", held_min);
    end
    checks++;
    if (held_max !== 4) begin
      errors++; $display("FAIL backpressure_hold_max: got %0d cycles want 4", held_max);
    end
    y_ready = 1'b1;
  endtask

  // X=0x0001 then X=0x0008 held valid: taken on the LAST beat, no bubble.
  task automatic test_back_to_back();
    logic [OW-1:0] want[4];
    want = '{8'b0_0_0000_0_1, 8'b1_1_0000_1_1, 8'b1_1_0011_1_1, 8'b0_0_0000_0_1};
    y_ready = 1'b1; x = 16'h0001; x_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs_min !== want[c]) begin
        errors++; $display("FAIL back_to_back_min cyc%0d: got %b want %b", c, obs_min, want[c]);
      end
      checks++;
      if (obs_max !== want[c]) begin
        errors++; $display("FAIL back_to_back_max cyc%0d: got %b want %b", c, obs_max, want[c]);
      end
      tick();
      if (c == 0) x = 16'h0008;
      else x_valid = 1'b0;
    end
  endtask

  // X=0 accepted and dropped; then X=0xFFFF drains 16 beats, LAST only on final.
  task automatic test_zero_and_full();
    int lasts, beats;
    lasts = 0; beats = 0;
    y_ready = 1'b1; x = '0; x_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs_min !== 8'b0_0_0000_0_1) begin
        errors++; $display("FAIL zero_vector cyc%0d: got %b want %b", c, obs_min, 8'b0_0_0000_0_1);
      end
      tick();
      x_valid = 1'b0;
    end
    x = 16'hFFFF; x_valid = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (bus_min.Y_VALID) beats++;
      if (bus_min.Y_VALID && bus_min.Y_LAST) lasts++;
      checks++;
      if (obs_min !== model_out(1'b0, y_ready)) begin
        errors++; $display("FAIL full_vector_min cyc%0d: got %b want %b", c, obs_min, model_out(1'b0, y_ready));
      end
      checks++;
      if (obs_max !== model_out(1'b1, y_ready)) begin
        errors++; $display("FAIL full_vector_max cyc%0d: got %b want %b", c, obs_max, model_out(1'b1, y_ready));
      end
      tick();
      x_valid = 1'b0;
    end
    checks++;
    if (beats !== OPT || lasts !== 1) begin
      errors++; $display("FAIL full_vector_count: got beats=%0d lasts=%0d want beats=%0d lasts=1", beats, lasts, OPT);
    end
  endtask

  // Reset three beats into a full vector: output drops at once, no stale beats.
  task automatic test_reset_mid_emit();
    y_ready = 1'b1; x = 16'hFFFF; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs_min !== model_out(1'b0, y_ready)) begin
        errors++; $display("FAIL mid_reset_pre cyc%0d: got %b want %b", c, obs_min, model_out(1'b0, y_ready));
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_min !== '0 || obs_max !== '0) begin
      errors++; $display("FAIL mid_reset_async: got min=%b max=%b want all zero", obs_min, obs_max);
    end
    exp_min_q.delete(); exp_max_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs_min !== 8'b0_0_0000_0_1 || obs_max !== 8'b0_0_0000_0_1) begin
        errors++; $display("FAIL mid_reset_after cyc%0d: got min=%b max=%b want %b", c, obs_min, obs_max, 8'b0_0_0000_0_1);
      end
      tick();
    end
  endtask

  // Random vectors, valid and ready against the queue model.
  task automatic test_random();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        x_valid = ($urandom_range(0, 99) < 60);
        y_ready = ($urandom_range(0, 99) < 70);
        case ($urandom_range(0, 3))
          0:       x = '0;
          1:       x = OPT'(1) << $urandom_range(0, OPT - 1);
          2:       x = OPT'($urandom);
          default: x = OPT'($urandom) & OPT'($urandom);
        endcase
      end else begin
        x_valid = 1'b0;
        y_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (obs_min !== model_out(1'b0, y_ready)) begin
        errors++; $display("FAIL random_min cyc%0d: got %b want %b", c, obs_min, model_out(1'b0, y_ready));
      end
      checks++;
      if (obs_max !== model_out(1'b1, y_ready)) begin
        errors++; $display("FAIL random_max cyc%0d: got %b want %b", c, obs_max, model_out(1'b1, y_ready));
      end
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_min_order();
    test_max_order();
    test_backpressure();
    test_back_to_back();
    test_zero_and_full();
    test_reset_mid_emit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
